uart_tx_scheduler: RTL and testbench

Round-robin scheduler that shares one `uart` transmitter among `N_REQ` byte producers. It grants one requester at a time and latches its byte onto the transmitter's `data_in`. It then pulses `start` and owns the line for one full frame plus a guard gap before it grants again. The block sits directly in front of the `uart` instance and drives its `start` and `data_in` ports. The transmitter has no busy/done output, so the scheduler times frames itself.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rr_arbiter.sv | 64 ++++++
 rtl/uart_tx_scheduler.sv | 141 ++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_pkg;

    // Scheduler states; IDLE is the only state in which a grant can happen.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        FRAME  = 2'd2,
        GAP    = 2'd3
    } sched_state_t;

    // Bits on the wire per frame: start + 8 data + stop.
    localparam int UART_FRAME_BITS = 10;

    // 9600 baud at 100 MHz.
    localparam int DEFAULT_CLKS_PER_BIT = 10416;

endpackage

// File: rtl/uart_rr_arbiter.sv
// Winner select for the UART scheduler. Round-robin by default: the search
// starts at the pointer and wraps upward; the pointer moves past the winner
// whenever a grant is taken (advance). With UART_SCHED_FIXED_PRIO_EN defined,
// the lowest-index requester always wins and no pointer exists.
module uart_rr_arbiter #(
    parameter int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             advance,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_any
);

`ifdef UART_SCHED_FIXED_PRIO_EN

    // Lowest index wins: scan downward so the last hit is the smallest index.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                grant_any = 1'b1;
                grant_idx = IDX_W'(k);
            end
        end
    end

`else

    logic [IDX_W-1:0] ptr_q;
    int               cand;

    // Pointer points just past the last winner so every requester gets a turn.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else if (advance) begin
            ptr_q <= (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end

    // Scan offsets from far to near so the nearest requester after the pointer wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = int'(ptr_q) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (req[cand]) begin
                grant_any = 1'b1;
                grant_idx = IDX_W'(cand);
            end
        end
    end

`endif

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among N_REQ byte producers. A grant latches the
// winner's byte onto uart_data, raises uart_start for START_HOLD cycles, then
// holds the line for the rest of the frame plus GAP_CYCLES before the next
// grant. The transmitter gives no done indication, so the frame is timed here.
// Optional macro: UART_SCHED_FIXED_PRIO_EN selects fixed lowest-index priority.
//
// Handshake: a requester holds req_valid[i] high with stable data until it sees
// the single-cycle req_ack[i]; the byte is captured on that same edge and the
// requester may present its next byte from the following cycle on.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int START_HOLD   = 10,
    parameter int GAP_CYCLES   = 16,
    localparam int IDX_W       = $clog2(N_REQ)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   req_ack,
    output logic               uart_start,
    output logic [7:0]         uart_data,
    output logic               busy,
    output logic [IDX_W-1:0]   owner,
    output logic [1:0]         state_dbg
);

    localparam int FRAME_CYCLES = UART_FRAME_BITS * CLKS_PER_BIT;
    localparam int CNT_W        = $clog2(FRAME_CYCLES + 1);

    // Each load is "cycles in state minus one"; the state exits when the count is 0.
    // LAUNCH plus FRAME together span exactly one frame measured from the first start cycle.
    localparam logic [CNT_W-1:0] LAUNCH_LOAD = CNT_W'(START_HOLD - 1);
    localparam logic [CNT_W-1:0] FRAME_LOAD  = CNT_W'(FRAME_CYCLES - START_HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    sched_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             advance;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_any;

    uart_rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .clock     (clock),
        .reset     (reset),
        .req       (req_valid),
        .advance   (advance),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // State and shared down-counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; the counter reloads on every state entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        advance = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    state_d = LAUNCH;
                    cnt_d   = LAUNCH_LOAD;
                    advance = 1'b1;
                end
            end
            LAUNCH: begin
                if (cnt_q == '0) begin
                    state_d = FRAME;
                    cnt_d   = FRAME_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            FRAME: begin
                if (cnt_q == '0) begin
                    if (GAP_CYCLES == 0) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = GAP;
                        cnt_d   = GAP_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Grant-edge captures: byte, owner and a one-cycle ack to the winner.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            req_ack   <= '0;
            uart_data <= '0;
            owner     <= '0;
        end else begin
            req_ack <= '0;
            if (advance) begin
                req_ack[grant_idx] <= 1'b1;
                uart_data          <= req_data[{grant_idx, 3'b000} +: 8];
                owner              <= grant_idx;
            end
        end
    end

    // Start and busy decode straight from the state register, so an async
    // reset drops them in the same cycle.
    always_comb begin
        uart_start = (state_q == LAUNCH);
        busy       = (state_q != IDLE);
        state_dbg  = state_q;
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed testbench for uart_tx_scheduler with N_REQ=4, CLKS_PER_BIT=4,
// START_HOLD=2, GAP_CYCLES=3 (frame 40 cycles, grant spacing 44 cycles).
module tb_uart_tx_scheduler;

    logic        clock;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ack;
    logic        uart_start;
    logic [7:0]  uart_data;
    logic        busy;
    logic [1:0]  owner;
    logic [1:0]  state_dbg;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int ack_cyc;
    int prev_cyc;
    logic ack3_seen;

    uart_tx_scheduler #(
        .N_REQ        (4),
        .CLKS_PER_BIT (4),
        .START_HOLD   (2),
        .GAP_CYCLES   (3)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ack    (req_ack),
        .uart_start (uart_start),
        .uart_data  (uart_data),
        .busy       (busy),
        .owner      (owner),
        .state_dbg  (state_dbg)
    );

    // clock / reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (req_ack[3]) ack3_seen <= 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait for the next ack (bounded) and compare it; records the cycle it appeared.
    task automatic wait_ack(input string tag, input logic [3:0] exp_ack);
        int n = 0;
        @(negedge clock);
        while (req_ack == 4'b0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_ack"}, 32'(req_ack), 32'(exp_ack));
        ack_cyc = cyc;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = 4'hF;
        req_data  = 32'hA3A2A1A0;
        ack3_seen = 1'b0;

        // 1: reset holds every output at zero, then requester 0 goes first
        repeat (3) @(negedge clock);
        check("rst_ack",   32'(req_ack),    32'd0);
        check("rst_start", 32'(uart_start), 32'd0);
        check("rst_data",  32'(uart_data),  32'd0);
        check("rst_busy",  32'(busy),       32'd0);
        check("rst_owner", 32'(owner),      32'd0);
        check("rst_state", 32'(state_dbg),  32'd0);
        reset = 1'b1;
        wait_ack("first", 4'b0001);
        req_valid = 4'b0;
        wait_idle("first");

        // 2: single request, byte BA
        req_valid = 4'b0001;
        req_data  = 32'h000000BA;
        wait_ack("single", 4'b0001);
        prev_cyc = ack_cyc;
        req_valid = 4'b0;
        check("single_data",   32'(uart_data),  32'hBA);
        check("single_start0", 32'(uart_start), 32'd1);
        check("single_busy0",  32'(busy),       32'd1);
        @(negedge clock);
        check("single_ack_pulse", 32'(req_ack),    32'd0);
        check("single_start1",    32'(uart_start), 32'd1);
        @(negedge clock);
        check("single_start2", 32'(uart_start), 32'd0);
        check("single_hold",   32'(uart_data),  32'hBA);
        wait_idle("single");
        check("single_busy_len", 32'(cyc - prev_cyc), 32'd43);
        @(negedge clock);
        check("single_idle1", 32'(state_dbg), 32'd0);

`ifndef UART_SCHED_FIXED_PRIO_EN
        // 3: all four requesting continuously: 0,1,2,3,0 spaced 44 cycles
        pulse_reset();
        req_data  = 32'hA3A2A1A0;
        req_valid = 4'hF;
        begin
            logic [3:0] exp_ack [5];
            logic [1:0] exp_own [5];
            exp_ack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
            exp_own = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
            for (int g = 0; g < 5; g++) begin
                wait_ack($sformatf("rr%0d", g), exp_ack[g]);
                check($sformatf("rr%0d_owner", g), 32'(owner), 32'(exp_own[g]));
                check($sformatf("rr%0d_data", g), 32'(uart_data), 32'hA0 + 32'(exp_own[g]));
                if (g > 0) check($sformatf("rr%0d_space", g), 32'(ack_cyc - prev_cyc), 32'd44);
                prev_cyc = ack_cyc;
            end
        end
        req_valid = 4'b0;
        wait_idle("rr");

        // 4: requester 1 granted, 0 and 3 arrive mid-frame: 3 then 0
        req_valid = 4'b0010;
        req_data  = 32'h33221100;
        wait_ack("late_r1", 4'b0010);
        req_valid = 4'b0;
        repeat (5) @(negedge clock);
        req_valid = 4'b1001;
        wait_ack("late_r3", 4'b1000);
        check("late_r3_data", 32'(uart_data), 32'h33);
        req_valid = 4'b0001;
        wait_ack("late_r0", 4'b0001);
        check("late_r0_data", 32'(uart_data), 32'h00);
        req_valid = 4'b0;
        wait_idle("late");
`endif

        // 5: reset mid-frame aborts; pointer restarts so requester 2 beats 3
        req_valid = 4'b0100;
        req_data  = 32'h775C0000;
        wait_ack("abort_pre", 4'b0100);
        req_valid = 4'b0;
        repeat (10) @(negedge clock);
        check("abort_in_frame", 32'(state_dbg), 32'd2);
        req_valid = 4'b1100;
        reset = 1'b0;
        #1;
        check("abort_start", 32'(uart_start), 32'd0);
        check("abort_busy",  32'(busy),       32'd0);
        check("abort_ack",   32'(req_ack),    32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        wait_ack("abort_post", 4'b0100);
        check("abort_owner", 32'(owner),     32'd2);
        check("abort_data",  32'(uart_data), 32'h5C);
        req_valid = 4'b1000;
        wait_ack("abort_next", 4'b1000);
        req_valid = 4'b0;
        wait_idle("abort");

        // 6: requesters 0 and 3 continuously
        pulse_reset();
        ack3_seen = 1'b0;
        req_data  = 32'hD3000000 | 32'h000000D0;
        req_valid = 4'b1001;
`ifdef UART_SCHED_FIXED_PRIO_EN
        for (int g = 0; g < 3; g++) begin
            wait_ack($sformatf("fix%0d", g), 4'b0001);
            check($sformatf("fix%0d_data", g), 32'(uart_data), 32'hD0);
        end
        req_valid = 4'b0;
        wait_idle("fix");
        check("fix_no_ack3", 32'(ack3_seen), 32'd0);
`else
        wait_ack("alt0", 4'b0001);
        check("alt0_data", 32'(uart_data), 32'hD0);
        wait_ack("alt1", 4'b1000);
        check("alt1_data", 32'(uart_data), 32'hD3);
        wait_ack("alt2", 4'b0001);
        req_valid = 4'b0;
        wait_idle("alt");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
